// File: rtl/song_sequencer_if.sv
// Control and ROM bus between a song controller and the song sequencer.
// The master drives the transport controls and returns ROM data; the slave
// (the sequencer) drives the ROM address and the buzzer-facing outputs.
interface song_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              pause;
    logic              stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [8:0]        rom_data;
    logic [7:0]        notes;
    logic [1:0]        shift;
    logic              busy;
    logic              done;

    modport master (
        output start, pause, stop, rom_data,
        input  rom_addr, notes, shift, busy, done
    );

    modport slave (
        input  start, pause, stop, rom_data,
        output rom_addr, notes, shift, busy, done
    );
endinterface

// File: rtl/song_sequencer.sv
// Auto-play source for the buzzer path: walks a song table in an external
// synchronous ROM (one-cycle read latency) and drives one-hot notes plus an
// octave shift. Each entry plays for duration*TICK_DIV cycles followed by a
// GAP_CYC-cycle silence; a zero duration terminates the song.
module song_sequencer #(
    parameter int TICK_DIV = 6_250_000,
    parameter int GAP_CYC  = 1_000_000,
    parameter int SONG_LEN = 64,
    parameter int ADDR_W   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    song_sequencer_if.slave bus
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    // With GAP_CYC = 0 the GAP state is never entered, so this value is unused.
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP,
        NEXT,
        DONE
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [TICK_W-1:0] cyc_cnt_reg;
    logic [3:0]        tick_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [7:0]        note_latch_reg;
    logic [7:0]        notes_reg;
    logic [1:0]        shift_reg;
    logic              busy_reg;
    logic              done_reg;

    // Fields of the ROM entry currently presented on rom_data.
    logic [1:0] ent_shift;
    logic [2:0] ent_note;
    logic [3:0] ent_dur;
    logic [7:0] note_dec;

    assign ent_shift = bus.rom_data[8:7];
    assign ent_note  = bus.rom_data[6:4];
    assign ent_dur   = bus.rom_data[3:0];

    // Note 1..7 maps to one-hot bit 0..6; note 0 (rest) decodes to all zeros.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_note_dec
            assign note_dec[gi] = (ent_note == 3'(gi + 1));
        end
    endgenerate
    assign note_dec[7] = 1'b0;

    // Playback FSM with all outputs registered; stop has top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            cyc_cnt_reg    <= '0;
            tick_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            note_latch_reg <= '0;
            notes_reg      <= '0;
            shift_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else if (bus.stop) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            notes_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    notes_reg <= '0;
                    addr_reg  <= '0;
                    if (bus.start) begin
                        state_reg <= FETCH;
                        busy_reg  <= 1'b1;
                    end
                end
                FETCH: begin
                    state_reg <= LOAD;
                end
                LOAD: begin
                    if (ent_dur == 4'd0) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        shift_reg      <= ent_shift;
                        note_latch_reg <= note_dec;
                        notes_reg      <= note_dec;
                        tick_cnt_reg   <= ent_dur;
                        cyc_cnt_reg    <= '0;
                        state_reg      <= PLAY;
                    end
                end
                PLAY: begin
                    if (bus.pause) begin
                        // Counters hold; the latched note returns after release.
                        notes_reg <= '0;
                    end else if (cyc_cnt_reg == TICK_LAST) begin
                        cyc_cnt_reg <= '0;
                        if (tick_cnt_reg == 4'd1) begin
                            notes_reg   <= '0;
                            gap_cnt_reg <= '0;
                            state_reg   <= (GAP_CYC > 0) ? GAP : NEXT;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg - 4'd1;
                            notes_reg    <= note_latch_reg;
                        end
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                        notes_reg   <= note_latch_reg;
                    end
                end
                GAP: begin
                    if (!bus.pause) begin
                        if (gap_cnt_reg == GAP_LAST) begin
                            state_reg <= NEXT;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (addr_reg == ADDR_LAST) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        addr_reg  <= addr_reg + 1'b1;
                        state_reg <= FETCH;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    addr_reg  <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr = addr_reg;
    assign bus.notes    = notes_reg;
    assign bus.shift    = shift_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
endmodule
